shift_issue: RTL

SHIFT_ISSUE -- requirements
Module: shift_issue

---
 rtl/shift_issue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/shift_issue.sv
// Two-stage shift issue pipeline: decodes R-type shifts, drives an external barrel shifter
// from S1 and registers the result in S2. Define SHIFT_ISSUE_STATS_EN to add perf_count.
module shift_issue #(
  parameter bit RD_ZERO_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic [31:0] sh_d,
  output logic [4:0]  sh_sa,
  output logic        sh_right,
  output logic        sh_arith,
  input  logic [31:0] sh_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wreg,
  output logic        out_illegal
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [31:0] perf_count
`endif
);

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;

  // Decode
  logic       dec_legal;
  logic       dec_var;
  logic       dec_right;
  logic       dec_arith;
  logic [4:0] dec_sa;
  logic       dec_wreg;

  always_comb begin
    dec_legal = 1'b1;
    dec_var   = 1'b0;
    dec_right = 1'b0;
    dec_arith = 1'b0;
    case (in_funct)
      FnSll:  ;
      FnSrl:  dec_right = 1'b1;
      FnSra:  begin
        dec_right = 1'b1;
        dec_arith = 1'b1;
      end
      FnSllv: dec_var = 1'b1;
      FnSrlv: begin
        dec_var   = 1'b1;
        dec_right = 1'b1;
      end
      FnSrav: begin
        dec_var   = 1'b1;
        dec_right = 1'b1;
        dec_arith = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_sa   = dec_var ? in_rs[4:0] : in_shamt;
  assign dec_wreg = dec_legal && !(RD_ZERO_SUPPRESS && (in_rd == 5'd0));

  // Only the low five bits of rs carry a shift amount.
  logic unused_rs;
  assign unused_rs = ^in_rs[31:5];

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv;
  logic in_xfer;
  logic s2_xfer;
  logic retire;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign s2_xfer  = s1_valid_q && s1_adv;
  assign retire   = s2_valid_q && out_ready;

  // flush wins over any transfer happening in the same cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready) s1_valid_d = in_valid;
      if (s1_adv)   s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // S1: decoded operation, feeds the shifter directly
  logic [31:0] s1_d_q;
  logic [4:0]  s1_sa_q;
  logic        s1_right_q;
  logic        s1_arith_q;
  logic [4:0]  s1_rd_q;
  logic        s1_wreg_q;
  logic        s1_illegal_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_d_q       <= '0;
      s1_sa_q      <= '0;
      s1_right_q   <= 1'b0;
      s1_arith_q   <= 1'b0;
      s1_rd_q      <= '0;
      s1_wreg_q    <= 1'b0;
      s1_illegal_q <= 1'b0;
    end else if (in_xfer && !flush) begin
      s1_d_q       <= in_rt;
      s1_sa_q      <= dec_sa;
      s1_right_q   <= dec_right;
      s1_arith_q   <= dec_arith;
      s1_rd_q      <= in_rd;
      s1_wreg_q    <= dec_wreg;
      s1_illegal_q <= !dec_legal;
    end
  end

  assign sh_d     = s1_d_q;
  assign sh_sa    = s1_sa_q;
  assign sh_right = s1_right_q;
  assign sh_arith = s1_arith_q;

  // S2: registered result, held while the consumer stalls
  logic [31:0] out_data_q;
  logic [4:0]  out_rd_q;
  logic        out_wreg_q;
  logic        out_illegal_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_data_q    <= '0;
      out_rd_q      <= '0;
      out_wreg_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (s2_xfer && !flush) begin
      out_data_q    <= s1_illegal_q ? 32'd0 : sh_result;
      out_rd_q      <= s1_rd_q;
      out_wreg_q    <= s1_wreg_q;
      out_illegal_q <= s1_illegal_q;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign out_wreg    = out_wreg_q;
  assign out_illegal = out_illegal_q;

`ifdef SHIFT_ISSUE_STATS_EN
  // Saturating count of legal retirements; flush does not touch it.
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_q <= '0;
    end else if (retire && !out_illegal_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_count = perf_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
